// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronised board-reset release followed by staggered per-channel
// release, plus software-requested reset pulses on a masked subset of channels.
module rst_seq_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int MIN_PULSE   = 16,
  parameter int RELEASE_GAP = 4
) (
  input  logic              axi_aclk,
  input  logic              axi_resetn,
  input  logic              sw_rst_req,
  input  logic [CNT_W-1:0]  sw_rst_cycles,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] rstn_out,
  output logic              sw_rst_ack,
  output logic              rst_busy,
  output logic              rst_done
);

  typedef enum logic [1:0] {POR_HOLD, ASSERT, RELEASE, IDLE} state_t;

  localparam int                GAP_W    = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam logic [CNT_W-1:0]  MIN_L    = CNT_W'(MIN_PULSE);
  localparam logic [NUM_CH-1:0] ONE_BIT  = NUM_CH'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rst_sync_n;

  state_t            state_reg,   state_next;
  logic [CNT_W-1:0]  cnt_reg,     cnt_next;
  logic [CNT_W-1:0]  len_reg,     len_next;
  logic [GAP_W-1:0]  gap_reg,     gap_next;
  logic [NUM_CH-1:0] pending_reg, pending_next;
  logic [NUM_CH-1:0] rstn_reg,    rstn_next;
  logic              ack_reg,     ack_next;
  logic              busy_reg,    busy_next;
  logic              done_reg,    done_next;

  logic              do_release;
  logic [NUM_CH-1:0] rel_bit;
  logic [NUM_CH-1:0] pending_after;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge axi_aclk or negedge axi_resetn) begin
          if (!axi_resetn) sync_reg[gi] <= 1'b0;
          else             sync_reg[gi] <= 1'b1;
        end
      end else begin : g_next
        always_ff @(posedge axi_aclk or negedge axi_resetn) begin
          if (!axi_resetn) sync_reg[gi] <= 1'b0;
          else             sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rst_sync_n = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_reg   <= POR_HOLD;
      cnt_reg     <= '0;
      len_reg     <= MIN_L;
      gap_reg     <= '0;
      pending_reg <= '1;
      rstn_reg    <= '0;
      ack_reg     <= 1'b0;
      busy_reg    <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      gap_reg     <= gap_next;
      pending_reg <= pending_next;
      rstn_reg    <= rstn_next;
      ack_reg     <= ack_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    len_next     = len_reg;
    gap_next     = gap_reg;
    pending_next = pending_reg;
    rstn_next    = rstn_reg;
    ack_next     = 1'b0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    do_release   = 1'b0;
    // Lowest still-pending channel; non-target channels are skipped for free.
    rel_bit       = pending_reg & (~pending_reg + ONE_BIT);
    pending_after = pending_reg & ~rel_bit;

    case (state_reg)
      POR_HOLD: begin
        if (rst_sync_n) begin
          if (cnt_reg == MIN_L - CNT_W'(1)) do_release = 1'b1;
          else                               cnt_next   = cnt_reg + CNT_W'(1);
        end
      end
      ASSERT: begin
        if (cnt_reg == len_reg - CNT_W'(1)) do_release = 1'b1;
        else                                 cnt_next   = cnt_reg + CNT_W'(1);
      end
      RELEASE: begin
        if (gap_reg == GAP_W'(RELEASE_GAP - 1)) do_release = 1'b1;
        else                                     gap_next   = gap_reg + GAP_W'(1);
      end
      IDLE: begin
        if (sw_rst_req && |ch_mask) begin
          pending_next = ch_mask;
          len_next     = (sw_rst_cycles < MIN_L) ? MIN_L : sw_rst_cycles;
          rstn_next    = rstn_reg & ~ch_mask;
          cnt_next     = '0;
          ack_next     = 1'b1;
          busy_next    = 1'b1;
          state_next   = ASSERT;
        end
      end
      default: state_next = POR_HOLD;
    endcase

    if (do_release) begin
      rstn_next    = rstn_reg | rel_bit;
      pending_next = pending_after;
      cnt_next     = '0;
      gap_next     = '0;
      if (pending_after == '0) begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end else begin
        state_next = RELEASE;
      end
    end
  end

  assign rstn_out   = rstn_reg;
  assign sw_rst_ack = ack_reg;
  assign rst_busy   = busy_reg;
  assign rst_done   = done_reg;

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Synthesizable, parametrised reset sequencer for the DMA subsystem, replacing the single-output clock/reset generator.
- Synchronizes deassertion of the board reset and drives NUM_CH per-domain active-low resets, released one at a time with a fixed gap.
- Supports software-requested reset pulses on a masked subset of channels, with a guaranteed minimum pulse width and busy/ack/done status.

Parameters:
- NUM_CH, 4, number of reset output channels (>=1)
- SYNC_STAGES, 2, deassertion synchronizer depth (>=2)
- CNT_W, 8, width of the pulse-length counter and of sw_rst_cycles
- MIN_PULSE, 16, minimum reset assertion in cycles (1..2^CNT_W-1)
- RELEASE_GAP, 4, cycles between consecutive channel releases (>=1)

Ports:
- axi_aclk  in  1  system clock
- axi_resetn  in  1  asynchronous active-low reset
- sw_rst_req  in  1  software reset request, sampled on posedge
- sw_rst_cycles  in  CNT_W  requested pulse length in cycles; effective length L = max(sw_rst_cycles, MIN_PULSE)
- ch_mask  in  NUM_CH  channels affected by a software request
- rstn_out  out  NUM_CH  per-channel active-low reset
- sw_rst_ack  out  1  one-cycle pulse when a request is accepted
- rst_busy  out  1  high while any sequence is in progress
- rst_done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset is one clock domain, asynchronous, active-low. On axi_resetn=0 all flops clear immediately, without a clock:
  - rstn_out=0 (all channels)
  - rst_busy=1
  - sw_rst_ack=0, rst_done=0
  - synchronizer=0
  - state=POR_HOLD
- Deassertion goes through a SYNC_STAGES flop chain whose flops are async-cleared by axi_resetn. Internal rst_sync_n rises SYNC_STAGES posedges after axi_resetn rises.
- FSM states are POR_HOLD, ASSERT, RELEASE and IDLE.
- POR_HOLD:
  - Counts MIN_PULSE cycles after rst_sync_n=1.
  - Then enters RELEASE with target set = all channels.
  - With E1 = the first posedge with axi_resetn=1, rstn_out[0] rises at posedge E(SYNC_STAGES+MIN_PULSE).
- RELEASE:
  - Releases target channels in ascending index order.
  - Each next target channel rises RELEASE_GAP posedges after the previous one.
  - Non-target channels are skipped with no delay and keep their current value.
  - On the posedge that raises the final target channel: rst_done=1 for one cycle, rst_busy falls to 0, state goes to IDLE.
- IDLE:
  - A request is accepted when sw_rst_req=1 and ch_mask!=0 at a posedge P.
  - On acceptance, register mask M and length L. At the same edge P: rstn_out[M]=0, sw_rst_ack=1 (one cycle), rst_busy=1, state goes to ASSERT.
  - Requests with ch_mask==0 are ignored: no ack, no state change.
- ASSERT:
  - Holds masked channels low.
  - The first masked channel rises at P+L, then RELEASE proceeds over M.
  - Unmasked channels stay high throughout.
- sw_rst_req is ignored in every state except IDLE. A request held high across completion is re-accepted at the first IDLE posedge.
- sw_rst_cycles=0 or any value below MIN_PULSE gives L=MIN_PULSE. Counter comparisons use CNT_W bits with no wrap.
- axi_resetn asserted mid-sequence (any state) aborts it: all outputs take their reset values asynchronously, then the full POR sequence restarts on every channel.
- Outputs are registered; no combinational path exists from inputs to outputs.

Test Plan:
- POR, defaults: release axi_resetn, E1 = first posedge after release -> rstn_out[0..3] rise at posedges E18/E22/E26/E30; rst_done is a one-cycle pulse at E30; rst_busy goes 1->0 at E30.
- SW reset, ch_mask=4'b1010, sw_rst_cycles=40, accepted at P -> ack pulse at P; rstn_out[1],[3] fall at P; [1] rises at P+40, [3] at P+44; [0],[2] stay 1; done at P+44.
- Pulse clamping: sw_rst_cycles=5, then sw_rst_cycles=0, with ch_mask=4'b0001 -> rstn_out[0] low for exactly 16 cycles in both cases.
- Ignored requests: ch_mask=0 in IDLE -> no ack, no output change; a second sw_rst_req during ASSERT -> no second ack, original timing unchanged.
- Mid-operation reset: axi_resetn=0 for 3 cycles, applied 10 cycles into a sw ASSERT on mask 4'b0110 -> all rstn_out go 0 immediately (asynchronously); the POR sequence then repeats with E18..E30 timing on all channels.
- Parameter sweep: NUM_CH=1, RELEASE_GAP=1, MIN_PULSE=1, SYNC_STAGES=3 -> rstn_out[0] rises at E4; done at E4.
